// File: rtl/fifo_pkg.sv
// Shared defaults and derived constants for the fifo block.
package fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned FIFO_ENTRIES   = 2 ** DEF_FIFO_DEPTH;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Register-file storage: one write port, one asynchronous read port, cleared on reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DW = DEF_DATA_WIDTH,
  parameter int unsigned AW = DEF_FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned ENTRIES = 2 ** AW;

  logic [DW-1:0] mem [ENTRIES];

  // Storage write; every entry returns to zero while reset is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : fifo_mem

// File: rtl/fifo.sv
// Single-clock FIFO with registered read data and count-derived status flags.
module fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_DEPTH:0]   count
);

  localparam int unsigned CW      = FIFO_DEPTH + 1;
  localparam int unsigned ENTRIES = 2 ** FIFO_DEPTH;

  logic [FIFO_DEPTH-1:0] wptr;
  logic [FIFO_DEPTH-1:0] rptr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rd_ok_c;
  logic                  wr_ok_c;

  // Flags decode the registered count, so they can never both be set.
  assign full  = (count == CW'(ENTRIES));
  assign empty = (count == CW'(0));

  // A read frees a slot for a same-cycle write when full; no fall-through when empty.
  assign rd_ok_c = rd_en && !empty;
  assign wr_ok_c = wr_en && (!full || rd_ok_c);

  fifo_mem #(
    .DW (DATA_WIDTH),
    .AW (FIFO_DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (n_rst),
    .we    (wr_ok_c),
    .waddr (wptr),
    .wdata (din),
    .raddr (rptr),
    .rdata (rdata)
  );

  // Pointers, occupancy and read-data register.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      if (wr_ok_c) begin
        wptr <= wptr + FIFO_DEPTH'(1);
      end
      if (rd_ok_c) begin
        rptr <= rptr + FIFO_DEPTH'(1);
        dout <= rdata;
      end
      case ({wr_ok_c, rd_ok_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : fifo

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed scenarios plus random traffic against a queue model.
module tb_fifo;
  import fifo_pkg::*;

  localparam int unsigned DW  = DEF_DATA_WIDTH;
  localparam int unsigned AW  = DEF_FIFO_DEPTH;
  localparam int unsigned CAP = FIFO_ENTRIES;

  logic          clk;
  logic          n_rst;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;
  logic [AW:0]   count;

  int n_cmp;
  int n_err;

  // Reference model: plain queue of stored words plus the last word read.
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout;

  fifo dut (
    .clk   (clk),
    .n_rst (n_rst),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_dout"},  32'(dout),  32'(exp_dout));
    chk({tag, "_count"}, 32'(count), 32'(q.size()));
    chk({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, "_full"},  32'(full),  32'(q.size() == CAP));
  endtask

  // One clock with the given requests; model applies the acceptance rules, then compare.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
    bit rd_ok;
    bit wr_ok;
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    rd_ok = r && (q.size() > 0);
    wr_ok = w && ((q.size() < CAP) || rd_ok);
    if (rd_ok) exp_dout = q.pop_front();
    if (wr_ok) q.push_back(d);
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk_all(tag);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    exp_dout = '0;
    n_rst    = 1'b1;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    din      = '0;

    // Reset held two cycles with requests asserted: they must be ignored.
    wr_en = 1'b1;
    rd_en = 1'b1;
    din   = 8'hAA;
    repeat (2) @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_rst = 1'b0;
    chk_all("reset");

    // Fill 1..10, then read five.
    for (int i = 1; i <= 10; i++) step(1'b1, 1'b0, DW'(i), "fill");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0, "drain");
    chk("drain_last", 32'(dout), 32'd5);

    // Asynchronous reset between clock edges clears state without an edge.
    #2;
    n_rst = 1'b1;
    #1;
    q.delete();
    exp_dout = '0;
    chk_all("async_rst");
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    chk_all("async_rel");

    // Overflow: fill to capacity, dropped write, drain, extra read.
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, DW'(i), "ovf_fill");
    step(1'b1, 1'b0, 8'd99, "ovf_drop");
    for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, '0, "ovf_drain");
    chk("ovf_last", 32'(dout), 32'd16);
    step(1'b0, 1'b1, '0, "rd_empty");

    // Pointer wrap-around.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, DW'($urandom), "wrap_w12");
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, '0, "wrap_r12");
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'(8'h20 + i), "wrap_w8");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, "wrap_r8");
    chk("wrap_last", 32'(dout), 32'h27);

    // Simultaneous access at count=3, empty and full.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(8'h40 + i), "sim_pre");
    step(1'b1, 1'b1, 8'h50, "sim_mid");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, "sim_drain");
    step(1'b1, 1'b1, 8'h60, "sim_empty");
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, DW'($urandom), "sim_fill");
    step(1'b1, 1'b1, 8'h70, "sim_full");

    // Random traffic: write-biased then read-biased phases to reach both extremes.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 99) < 65), ($urandom_range(0, 99) < 45), DW'($urandom), "rand_w");
    end
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 60), DW'($urandom), "rand_r");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fifo
